// File: rtl/up_down_counter_if.sv
// Control/status bundle for up_down_counter: load/count controls in, value and terminal-count flag out.
interface up_down_counter_if #(
  parameter int N = 11
);
  logic         Load;
  logic [N-1:0] In;
  logic         En;
  logic         Din;
  logic [N-1:0] Out;
  logic         Cout;

  modport master (output Load, In, En, Din, input Out, Cout);
  modport slave  (input Load, In, En, Din, output Out, Cout);
endinterface

// File: rtl/up_down_counter.sv
// N-bit up/down counter with parallel load, count enable and combinational terminal-count flag.
// Optional build macro UPDOWN_SATURATE_EN: saturate at the end values instead of wrapping.
module up_down_counter #(
  parameter int N = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  up_down_counter_if.slave     bus
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic         at_term_s;

  // Terminal value for the selected direction: all-ones going up, zero going down.
  always_comb begin
    at_term_s = 1'b0;
    if (bus.Din) begin
      at_term_s = (cnt_q == CNT_ZERO);
    end else begin
      at_term_s = (cnt_q == CNT_MAX);
    end
  end

  // Next count: load beats count, count beats hold.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.Load) begin
      cnt_d = bus.In;
    end else if (bus.En) begin
`ifdef UPDOWN_SATURATE_EN
      if (at_term_s) begin
        cnt_d = cnt_q;
      end else if (bus.Din) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
`else
      if (bus.Din) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
`endif
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.Out = cnt_q;
  // Gated by rst_n so controls left active during reset cannot raise the flag.
  assign bus.Cout = rst_n & ~bus.Load & bus.En & at_term_s;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter: directed boundary cases then randomized traffic vs. a reference model.
module tb_up_down_counter;

  localparam int N = 11;
  localparam int M = 1 << N;
  localparam int MAX = M - 1;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   ref_val;

  up_down_counter_if #(.N(N)) u_if ();

  up_down_counter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_next(input int cur, input bit ld, input int din_val,
                                    input bit en, input bit dn);
    int nxt;
    nxt = cur;
    if (ld) nxt = din_val;
    else if (en) begin
`ifdef UPDOWN_SATURATE_EN
      if (dn) nxt = (cur == 0) ? 0 : cur - 1;
      else    nxt = (cur == MAX) ? MAX : cur + 1;
`else
      if (dn) nxt = (cur + M - 1) % M;
      else    nxt = (cur + 1) % M;
`endif
    end
    return nxt;
  endfunction

  function automatic int model_cout();
    if (!rst_n || u_if.Load || !u_if.En) return 0;
    if (u_if.Din) return (ref_val == 0) ? 1 : 0;
    return (ref_val == MAX) ? 1 : 0;
  endfunction

  // One rising edge; model advances with the inputs held across that edge.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (!rst_n) ref_val = 0;
    else ref_val = model_next(ref_val, u_if.Load, int'(u_if.In), u_if.En, u_if.Din);
    check(tag, int'(u_if.Out), ref_val);
  endtask

  task automatic drive(input bit ld, input int val, input bit en, input bit dn);
    u_if.Load = ld;
    u_if.In   = val[N-1:0];
    u_if.En   = en;
    u_if.Din  = dn;
    #1;
  endtask

  task automatic check_cout(input string tag);
    check(tag, int'(u_if.Cout), model_cout());
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    ref_val = 0;
    rst_n   = 1'b0;
    u_if.Load = 1'($urandom_range(1));
    u_if.In   = N'($urandom_range(MAX));
    u_if.En   = 1'b1;
    u_if.Din  = 1'b1;
    #2;
    check("reset_out_no_edge", int'(u_if.Out), 0);
    check("reset_cout_no_edge", int'(u_if.Cout), 0);
    drive(1'b0, 0, 1'b1, 1'b1);
    check("reset_cout_gated", int'(u_if.Cout), 0);
    tick("reset_held_out");
    drive(1'b1, 777, 1'b1, 1'b0);
    tick("reset_held_load");
    rst_n = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0);
    tick("release_hold");
    check("release_value", int'(u_if.Out), 0);

    // Load then count up, down, hold
    drive(1'b1, 123, 1'b0, 1'b0);
    tick("load_123");
    drive(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick("count_up");
    check("up_to_128", int'(u_if.Out), 128);
    drive(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick("count_down");
    check("down_to_118", int'(u_if.Out), 118);
    drive(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick("hold");
    check("hold_118", int'(u_if.Out), 118);

    // Up wrap / saturate
    drive(1'b1, MAX, 1'b0, 1'b0);
    tick("load_max");
    drive(1'b0, 0, 1'b1, 1'b0);
    check("up_term_cout", int'(u_if.Cout), 1);
    tick("up_wrap");
`ifdef UPDOWN_SATURATE_EN
    check("up_sat_value", int'(u_if.Out), MAX);
`else
    check("up_wrap_value", int'(u_if.Out), 0);
`endif

    // Down wrap / saturate
    drive(1'b1, 0, 1'b0, 1'b0);
    tick("load_zero");
    drive(1'b0, 0, 1'b1, 1'b1);
    check("down_term_cout", int'(u_if.Cout), 1);
    tick("down_wrap");
`ifdef UPDOWN_SATURATE_EN
    check("down_sat_value", int'(u_if.Out), 0);
`else
    check("down_wrap_value", int'(u_if.Out), MAX);
`endif

    // Load beats terminal count
    drive(1'b1, MAX, 1'b0, 1'b0);
    tick("load_max2");
    drive(1'b1, 5, 1'b1, 1'b0);
    check("load_prio_cout", int'(u_if.Cout), 0);
    tick("load_prio");
    check("load_prio_value", int'(u_if.Out), 5);

    // Async reset in the middle of counting
    drive(1'b0, 0, 1'b1, 1'b0);
    tick("pre_reset_count");
    rst_n = 1'b0;
    #1;
    ref_val = 0;
    check("async_reset_out", int'(u_if.Out), 0);
    check("async_reset_cout", int'(u_if.Cout), 0);
    #1;
    rst_n = 1'b1;
    tick("post_reset_count");
    check("post_reset_value", int'(u_if.Out), 1);

    // Randomized traffic, loads biased toward the terminal values
    for (int i = 0; i < 400; i++) begin
      int v;
      int sel;
      sel = int'($urandom_range(3));
      v = (sel == 0) ? 0 : (sel == 1) ? MAX : int'($urandom_range(MAX));
      drive(($urandom_range(7) == 0), v, 1'($urandom_range(1)) | 1'($urandom_range(1)),
            1'($urandom_range(1)));
      check_cout("rand_cout");
      if ($urandom_range(39) == 0) begin
        rst_n = 1'b0;
        #1;
        ref_val = 0;
        check("rand_async_reset", int'(u_if.Out), 0);
        rst_n = 1'b1;
      end
      tick("rand_out");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
